// File: rtl/div_nbit.sv
// -----------------------------------------------------------------------------
// div_nbit: iterative integer divider for the execute stage.
//
// Computes quotient and remainder with RISC-V M-extension semantics
// (DIV/DIVU/REM/REMU), including the divide-by-zero and signed-overflow cases.
// It is a restoring shift-subtract divider that produces one quotient bit per
// cycle. Trivial cases finish in a single cycle.
//
// A request tag travels with each operation. Any operation can be aborted with
// kill. The result is returned over a ready/valid handshake and stays on the
// outputs while the consumer applies backpressure.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request valid; accepted when start & ready
//   ready      high only while idle
//   is_signed  operands are two's complement when 1
//   dividend   dividend operand
//   divisor    divisor operand
//   tag_in     request tag, captured on accept
//   kill       synchronous abort of any in-flight or held operation
//   valid      result valid; held until out_ready
//   out_ready  consumer accepts the result when valid & out_ready
//   error      divide by zero (qualified by valid)
//   overflow   signed overflow (qualified by valid)
//   quotient   quotient result
//   remainder  remainder result
//   tag_out    tag of the returned result
//
// State table:
//   state  | meaning
//   IDLE   | waiting for a request; ready=1
//   DIVIDE | one restoring step per cycle, SIZE cycles in total
//   FIXUP  | applies the signs to the magnitude quotient and remainder
//   DONE   | result presented; valid=1 until out_ready or kill
// -----------------------------------------------------------------------------
module div_nbit #(
    parameter int SIZE  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic             ready,
    input  logic             is_signed,
    input  logic [SIZE-1:0]  dividend,
    input  logic [SIZE-1:0]  divisor,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill,
    output logic             valid,
    input  logic             out_ready,
    output logic             error,
    output logic             overflow,
    output logic [SIZE-1:0]  quotient,
    output logic [SIZE-1:0]  remainder,
    output logic [TAG_W-1:0] tag_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The most negative value. Its magnitude is 2^(SIZE-1), which still fits
    // in SIZE bits when it is treated as unsigned, so no extra bit is needed.
    localparam logic [SIZE-1:0] MIN_NEG  = {1'b1, {(SIZE-1){1'b0}}};
    localparam logic [SIZE-1:0] CNT_INIT = {1'b1, {(SIZE-1){1'b0}}};
    localparam logic [SIZE-1:0] CNT_LAST = {{(SIZE-1){1'b0}}, 1'b1};

    state_t              state;
    logic [2*SIZE-1:0]   div_sh;     // divisor magnitude, aligned and shifted right each step
    logic [SIZE-1:0]     cnt;        // one-hot quotient bit weight; also acts as the step counter
    logic                q_neg;      // negate the quotient in FIXUP
    logic                r_neg;      // negate the remainder in FIXUP

    logic                accept;
    logic                neg_a;
    logic                neg_b;
    logic [SIZE-1:0]     abs_a;
    logic [SIZE-1:0]     abs_b;
    logic                div_zero;
    logic                sgn_ovf;
    logic                small_q;
    logic [2*SIZE-1:0]   rem_ext;
    logic                fits;

    assign ready  = (state == IDLE);
    assign valid  = (state == DONE);
    assign accept = start & ready & ~kill;

    always_comb begin
        neg_a    = is_signed & dividend[SIZE-1];
        neg_b    = is_signed & divisor[SIZE-1];
        abs_a    = neg_a ? -dividend : dividend;
        abs_b    = neg_b ? -divisor  : divisor;
        div_zero = (divisor == '0);
        sgn_ovf  = is_signed & (dividend == MIN_NEG) & (divisor == '1);
        // If the divisor magnitude is larger than the dividend magnitude, the
        // quotient truncates to zero and the dividend is already the remainder.
        small_q  = (abs_b > abs_a);
        rem_ext  = {{SIZE{1'b0}}, remainder};
        fits     = (rem_ext >= div_sh);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            quotient  <= '0;
            remainder <= '0;
            error     <= 1'b0;
            overflow  <= 1'b0;
            tag_out   <= '0;
            div_sh    <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else if (kill) begin
            // Drop whatever is in progress or being held. The result registers
            // are left alone because they are don't-care while valid is low.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tag_out  <= tag_in;
                        error    <= 1'b0;
                        overflow <= 1'b0;
                        q_neg    <= neg_a ^ neg_b;
                        r_neg    <= neg_a;
                        if (div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            error     <= 1'b1;
                            state     <= DONE;
                        end else if (sgn_ovf) begin
                            quotient  <= dividend;
                            remainder <= '0;
                            overflow  <= 1'b1;
                            state     <= DONE;
                        end else if (small_q) begin
                            quotient  <= '0;
                            remainder <= dividend;
                            state     <= DONE;
                        end else begin
                            quotient  <= '0;
                            remainder <= abs_a;
                            div_sh    <= {{SIZE{1'b0}}, abs_b} << (SIZE-1);
                            cnt       <= CNT_INIT;
                            state     <= DIVIDE;
                        end
                    end
                end

                DIVIDE: begin
                    // When fits is set, div_sh <= remainder, so the upper half
                    // of div_sh is zero and a SIZE-bit subtract is exact.
                    if (fits) begin
                        remainder <= remainder - div_sh[SIZE-1:0];
                        quotient  <= quotient | cnt;
                    end
                    div_sh <= div_sh >> 1;
                    cnt    <= cnt >> 1;
                    if (cnt == CNT_LAST) begin
                        state <= FIXUP;
                    end
                end

                FIXUP: begin
                    if (q_neg) begin
                        quotient <= -quotient;
                    end
                    if (r_neg) begin
                        remainder <= -remainder;
                    end
                    state <= DONE;
                end

                DONE: begin
                    // Hold the result until it is taken. A start in the same
                    // cycle is not seen, because ready is low here.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/div_nbit.md
Name: div_nbit

Overview:
- Parametrised iterative integer divider. Handles signed and unsigned operands with RISC-V M-extension semantics: DIV/DIVU/REM/REMU, divide-by-zero and signed overflow.
- Sits beside the ALU in the execute stage and is driven by the mul/div issue logic.
- Restoring shift-subtract, 1 quotient bit per cycle, single-cycle early-outs.
- Adds what the earlier divider lacks: request tag, kill, and a ready/valid result handshake that holds the result under backpressure.

Parameters:
SIZE  32  operand/result width in bits (>=2)
TAG_W  4  width of request tag carried with the operation

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  request valid; accepted when start & ready
ready  out  1  high only in IDLE
is_signed  in  1  operands two's complement when 1
dividend  in  SIZE  dividend
divisor  in  SIZE  divisor
tag_in  in  TAG_W  request tag, captured on accept
kill  in  1  synchronous abort of any in-flight or held operation
valid  out  1  result valid; held until out_ready
out_ready  in  1  consumer accepts result when valid & out_ready
error  out  1  divide by zero (qualified by valid)
overflow  out  1  signed overflow (qualified by valid)
quotient  out  SIZE  quotient
remainder  out  SIZE  remainder
tag_out  out  TAG_W  tag of the returned result

Behaviour:
- Reset (async, reset_n=0): state=IDLE; valid, error, overflow, quotient, remainder and tag_out all 0. ready=1 combinationally from IDLE.
- States: IDLE, DIVIDE, FIXUP, DONE. ready = (IDLE); valid = (DONE).
- IDLE, start=1, kill=0: capture tag_in, is_signed, dividend sign, divisor sign. Then priority, first match wins:
  - divisor==0 -> DONE; q=all ones; r=dividend; error=1.
  - is_signed & dividend==1<<(SIZE-1) & divisor==all ones -> DONE; q=dividend; r=0; overflow=1.
  - |divisor| > |dividend| (magnitudes; unsigned compare when is_signed=0) -> DONE; q=0; r=dividend.
  - otherwise -> DIVIDE. Load remainder=|dividend|, q=0, shifted divisor=|divisor|<<(SIZE-1) in 2*SIZE bits, bit counter=1<<(SIZE-1).
- Magnitude of -2^(SIZE-1) is 2^(SIZE-1), held as SIZE-bit unsigned. No extra bit.
- DIVIDE, exactly SIZE cycles, each cycle:
  - if zero-extended remainder >= shifted divisor: subtract, OR counter into q.
  - shift divisor and counter right by 1.
  - leave DIVIDE after the cycle where counter==1 -> FIXUP.
- FIXUP, 1 cycle: if is_signed and signs differ, q=-q. If is_signed and dividend negative, r=-r. -> DONE.
- Latency, accept cycle = 0:
  - early-out: valid in cycle 1.
  - normal: DIVIDE cycles 1..SIZE, FIXUP cycle SIZE+1, valid in cycle SIZE+2.
- DONE: quotient, remainder, error, overflow and tag_out stable while valid=1 and out_ready=0.
  - valid & out_ready -> IDLE next cycle; ready=1 that cycle.
  - No bypass: a new start cannot be accepted in the same cycle as a result hand-off.
- error/overflow cleared on every accept. Outputs other than valid are don't-care when valid=0.
- kill (any state): state->IDLE next edge; valid=0 next cycle; no result produced.
  - kill has priority over start and over out_ready.
  - start with kill in IDLE is ignored.
- start while not IDLE: ignored, no queuing.
- Operand inputs are only sampled on accept; later changes have no effect.
- reset_n asserted mid-operation: immediate IDLE, outputs 0, pending op discarded.

Test Plan:
- SIZE=32, unsigned 100/7, tag 3, out_ready=1 -> valid only in cycle 34; q=14, r=2, tag_out=3, error=0, overflow=0.
- Signed: -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. 7/-2 -> q=0xFFFFFFFD, r=1. -8/-2 -> q=4, r=0. Each valid in cycle 34.
- Divide by zero: dividend 0x1234, divisor 0, signed and unsigned -> valid in cycle 1; q=0xFFFFFFFF, r=0x1234, error=1.
- 0x80000000 / 0xFFFFFFFF:
  - signed -> cycle 1; q=0x80000000, r=0, overflow=1.
  - unsigned -> cycle 1 early-out; q=0, r=0x80000000, overflow=0.
- Backpressure on 100/7: out_ready=0 for 5 cycles after valid -> outputs and tag stable, ready=0, further starts ignored. Then out_ready=1 -> valid drops next cycle, ready=1.
- Abort:
  - kill in cycle 10 of a divide -> IDLE in cycle 11, no valid pulse; a new 9/3 then returns q=3, r=0.
  - reset_n pulse mid-divide -> all outputs 0, ready=1.
